instruction_fetch: RTL and testbench

Instruction fetch unit that reads from the word-addressed, asynchronously-read instruction memory and delivers instructions to decode. It holds the fetch PC, drives the memory address, and buffers fetched words with their PCs in a small prefetch queue behind a valid/ready handshake. It supports branch/jump redirect with queue flush and a halt input. It is the read-side counterpart of the instruction memory. Memory writes stay with the program loader; this block never asserts a write.

---
 rtl/riscnet_fetch_pkg.sv | 23 ++
 rtl/fetch_queue.sv | 64 ++++++
 rtl/instruction_fetch.sv | 72 +++++++
 tb/tb_instruction_fetch.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/riscnet_fetch_pkg.sv
// Shared fetch-side constants and queue entry layout.
// Imported by the fetch queue and the fetch unit.
package riscnet_fetch_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 2048;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] pc_wrap(
    input logic [ADDR_W:0] v
  );
    int unsigned t;
    t = 32'(v) % MEM_WORDS;
    return t[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small prefetch FIFO of {pc, data} entries.
// Flush and reset empty it; push and pop may coincide.
module fetch_queue
  import riscnet_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  fetch_entry_t i_din,
  output fetch_entry_t o_dout,
  output logic [CW-1:0] o_count
);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  fetch_entry_t  r_mem [DEPTH];

  logic w_do_pop;
  logic w_do_push;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push &&
    ((r_count != CW'(DEPTH)) || w_do_pop);

  // pointer and occupancy bookkeeping
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= bump(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= bump(r_rd_ptr);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // entry storage, written only on an accepted push
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush && w_do_push)
      r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch PC, redirect/halt control and imem port.
// Fetched words are buffered in fetch_queue.
module instruction_fetch
  import riscnet_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_rd,
  output logic              imem_wn,
  output logic [ADDR_W-1:0] imem_address,
  output logic [DATA_W-1:0] imem_write_data,
  input  logic [DATA_W-1:0] imem_read_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [CW-1:0]     w_count;
  logic              w_pop;
  logic              w_push;
  fetch_entry_t      w_din;
  fetch_entry_t      w_head;

  assign inst_valid = (w_count != '0);
  assign w_pop  = inst_valid && inst_ready;
  assign w_push = !rst && !redirect_valid && !halt &&
    ((w_count < CW'(DEPTH)) || w_pop);

  assign w_din.pc   = r_fetch_pc;
  assign w_din.data = imem_read_data;

  // fetch PC: reset > redirect > advance on push
  always_ff @(posedge clk) begin
    if (rst)
      r_fetch_pc <= RESET_PC;
    else if (redirect_valid)
      r_fetch_pc <= pc_wrap({1'b0, redirect_pc});
    else if (w_push)
      r_fetch_pc <= pc_wrap({1'b0, r_fetch_pc} + 1'b1);
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_flush(redirect_valid),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_din  (w_din),
    .o_dout (w_head),
    .o_count(w_count)
  );

  assign inst_data = w_head.data;
  assign inst_pc   = w_head.pc;

  assign imem_rd         = 1'b1;
  assign imem_wn         = 1'b0;
  assign imem_address    = r_fetch_pc;
  assign imem_write_data = '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with an
// asynchronous-read instruction memory model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_rd;
  logic        imem_wn;
  logic [15:0] imem_address;
  logic [31:0] imem_write_data;
  logic [31:0] imem_read_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [15:0] inst_pc;

  logic [31:0] mem [0:2047];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_read_data = mem[imem_address[10:0]];

  always @(posedge clk) begin
    if (imem_wn) mem[imem_address[10:0]] <= imem_write_data;
  end

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_rd        (imem_rd),
    .imem_wn        (imem_wn),
    .imem_address   (imem_address),
    .imem_write_data(imem_write_data),
    .imem_read_data (imem_read_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("rd", 32'(imem_rd), 32'd1);
    chk("wn", 32'(imem_wn), 32'd0);
    chk("wdata", imem_write_data, 32'd0);
  endtask

  task automatic head(input string tag,
                      input logic [15:0] pc,
                      input logic [31:0] data);
    chk({tag, "_v"}, 32'(inst_valid), 32'd1);
    chk({tag, "_pc"}, 32'(inst_pc), 32'(pc));
    chk({tag, "_d"}, inst_data, data);
  endtask

  task automatic empty(input string tag);
    chk({tag, "_v"}, 32'(inst_valid), 32'd0);
    chk({tag, "_pc"}, 32'(inst_pc), 32'd0);
    chk({tag, "_d"}, inst_data, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'(i + 1);
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;
    inst_ready = 1'b0;

    // reset state
    step();
    step();
    empty("rst");
    chk("rst_addr", 32'(imem_address), 32'd0);

    // sequential fetch
    rst = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      head("seq", 16'(i), 32'(i + 1));
    end

    // backpressure
    rst = 1'b1;
    step();
    empty("rst2");
    rst = 1'b0;
    inst_ready = 1'b0;
    step();
    head("bp0", 16'd0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      head("bp_hold", 16'd0, 32'd1);
    end
    chk("bp_count", 32'(dut.w_count), 32'd2);
    chk("bp_addr", 32'(imem_address), 32'd2);
    inst_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      head("bp_rel", 16'(i), 32'(i + 1));
    end

    // redirect while head is pc 3
    redirect_valid = 1'b1;
    redirect_pc = 16'd6;
    step();
    empty("rd_gap");
    redirect_valid = 1'b0;
    step();
    head("rd6", 16'd6, 32'd7);
    step();
    head("rd7", 16'd7, 32'd8);

    // halt: drain and freeze fetch address
    halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      empty("halt");
      chk("halt_addr", 32'(imem_address), 32'd8);
    end

    // halt + redirect: redirect wins
    redirect_valid = 1'b1;
    redirect_pc = 16'd1;
    step();
    empty("hr");
    chk("hr_addr", 32'(imem_address), 32'd1);
    redirect_valid = 1'b0;
    halt = 1'b0;
    step();
    head("hr1", 16'd1, 32'd2);

    // wrap at MEM_WORDS
    redirect_valid = 1'b1;
    redirect_pc = 16'd2047;
    step();
    empty("wr_gap");
    redirect_valid = 1'b0;
    step();
    head("wr_top", 16'd2047, 32'd2048);
    step();
    head("wr_0", 16'd0, 32'd1);

    // fill, then reset with a pending redirect
    inst_ready = 1'b0;
    step();
    chk("full_count", 32'(dut.w_count), 32'd2);
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'd5;
    step();
    empty("mrst");
    chk("mrst_addr", 32'(imem_address), 32'd0);
    rst = 1'b0;
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    step();
    head("post_rst", 16'd0, 32'd1);

    // memory untouched
    for (int i = 0; i < 2048; i += 97)
      chk("mem", mem[i], 32'(i + 1));
    chk("mem_top", mem[2047], 32'd2048);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
